// File: rtl/ml_seq_ctrl.sv
// Sequencing controller for the 4x4 QPSK ML detector. It loads R and y_hat from a
// word stream, sweeps the 64 candidates, captures the LLRs and hands them downstream.
module ml_seq_ctrl #(
  parameter int DATA_WIDTH = 20,
  parameter int TIMEOUT    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [DATA_WIDTH-1:0]         i_in_data,
  input  logic                          i_in_is_r,
  output logic [16*DATA_WIDTH-1:0]      o_r,
  output logic [8*DATA_WIDTH-1:0]       o_y_hat,
  output logic                          o_det_enable,
  output logic [5:0]                    o_det_cnt,
  input  logic                          i_det_valid,
  input  logic [8*(DATA_WIDTH+2)-1:0]   i_llr,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [8*(DATA_WIDTH+2)-1:0]   o_out_llr,
  output logic                          o_busy,
  output logic                          o_err
);

  localparam int DW = DATA_WIDTH;
  localparam int LW = 8 * (DATA_WIDTH + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_R,
    S_LOAD_Y,
    S_SWEEP,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       word_cnt_q, word_cnt_d;
  logic [5:0]       sweep_cnt_q, sweep_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [16*DW-1:0] r_q, r_d;
  logic [8*DW-1:0]  y_q, y_d;
  logic [LW-1:0]    llr_q, llr_d;
  logic             r_loaded_q, r_loaded_d;
  logic             err_q, err_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      sweep_cnt_q <= '0;
      to_cnt_q    <= '0;
      r_q         <= '0;
      y_q         <= '0;
      llr_q       <= '0;
      r_loaded_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      to_cnt_q    <= to_cnt_d;
      r_q         <= r_d;
      y_q         <= y_d;
      llr_q       <= llr_d;
      r_loaded_q  <= r_loaded_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    to_cnt_d    = to_cnt_q;
    r_d         = r_q;
    y_d         = y_q;
    llr_d       = llr_q;
    r_loaded_d  = r_loaded_q;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The burst type is decided by the first word only; a y burst needs a loaded R.
        if (i_in_valid) begin
          if (i_in_is_r) begin
            r_d[DW-1:0] = i_in_data;
            word_cnt_d  = 4'd1;
            state_d     = S_LOAD_R;
          end else if (r_loaded_q) begin
            y_d[DW-1:0] = i_in_data;
            word_cnt_d  = 4'd1;
            state_d     = S_LOAD_Y;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD_R: begin
        if (i_in_valid) begin
          r_d[int'(word_cnt_q)*DW +: DW] = i_in_data;
          word_cnt_d = word_cnt_q + 4'd1;
          if (word_cnt_q == 4'd15) begin
            r_loaded_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_LOAD_Y: begin
        if (i_in_valid) begin
          y_d[int'(word_cnt_q[2:0])*DW +: DW] = i_in_data;
          word_cnt_d = word_cnt_q + 4'd1;
          if (word_cnt_q == 4'd7) begin
            word_cnt_d  = 4'd0;
            sweep_cnt_d = 6'd0;
            state_d     = S_SWEEP;
          end
        end
      end

      S_SWEEP: begin
        sweep_cnt_d = sweep_cnt_q + 6'd1;
        if (sweep_cnt_q == 6'd63) begin
          to_cnt_d = '0;
          state_d  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (i_det_valid) begin
          llr_d   = i_llr;
          state_d = S_OUT;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_OUT: begin
        if (i_out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from the state register so an async reset clears them at once.
  assign o_in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD_R) || (state_q == S_LOAD_Y);
  assign o_det_enable = (state_q == S_SWEEP);
  assign o_det_cnt    = (state_q == S_SWEEP) ? sweep_cnt_q : 6'd0;
  assign o_out_valid  = (state_q == S_OUT);
  assign o_busy       = (state_q != S_IDLE);
  assign o_err        = err_q;
  assign o_r          = r_q;
  assign o_y_hat      = y_q;
  assign o_out_llr    = llr_q;

endmodule

// File: tb/tb_ml_seq_ctrl.sv
// Directed bench for ml_seq_ctrl: loads, sweeps, LLR handoff, error paths and reset.
// All driving and sampling happens on the falling clock edge.
module tb_ml_seq_ctrl;

  localparam int DW = 20;
  localparam int LW = 8 * (DW + 2);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_is_r;
  logic [16*DW-1:0]  r_bus;
  logic [8*DW-1:0]   y_bus;
  logic              det_enable;
  logic [5:0]        det_cnt;
  logic              det_valid;
  logic [LW-1:0]     llr_in;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     out_llr;
  logic              busy;
  logic              err;

  int vectors;
  int miscompares;

  ml_seq_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_is_r    (in_is_r),
    .o_r          (r_bus),
    .o_y_hat      (y_bus),
    .o_det_enable (det_enable),
    .o_det_cnt    (det_cnt),
    .i_det_valid  (det_valid),
    .i_llr        (llr_in),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_llr    (out_llr),
    .o_busy       (busy),
    .o_err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [319:0] got, input logic [319:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mkLlr(input int base);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*(DW+2) +: (DW+2)] = (DW+2)'(base + k);
    return v;
  endfunction

  // Sends one word per cycle; is_r is flipped after the first word, which the DUT must ignore.
  task automatic applyStimulus(input int base, input int n, input logic is_r);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + k);
      in_is_r  = (k == 0) ? is_r : ~is_r;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_is_r  = 1'b0;
    in_data  = '0;
  endtask

  task automatic checkR(input int base);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("r_word%0d", k), 320'(r_bus[k*DW +: DW]), 320'(base + k));
  endtask

  task automatic checkY(input int base);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("y_word%0d", k), 320'(y_bus[k*DW +: DW]), 320'(base + k));
  endtask

  // Entered in the cycle after the last y word; leaves in the first DRAIN cycle.
  task automatic runSweep(input bit spurious);
    for (int k = 0; k < 64; k++) begin
      checkOutput("det_enable", 320'(det_enable), 320'(1));
      checkOutput("det_cnt", 320'(det_cnt), 320'(k));
      det_valid = (spurious && k == 10);
      @(negedge clk);
    end
    det_valid = 1'b0;
    checkOutput("drain_enable", 320'(det_enable), 320'(0));
    checkOutput("drain_cnt", 320'(det_cnt), 320'(0));
    checkOutput("drain_busy", 320'(busy), 320'(1));
    checkOutput("drain_in_ready", 320'(in_ready), 320'(0));
    checkOutput("drain_out_valid", 320'(out_valid), 320'(0));
  endtask

  // Detector model with nominal latency 5: valid lands four cycles into DRAIN.
  task automatic deliverLlr(input int base);
    for (int k = 0; k < 4; k++) @(negedge clk);
    checkOutput("pre_valid_out_valid", 320'(out_valid), 320'(0));
    det_valid = 1'b1;
    llr_in    = mkLlr(base);
    @(negedge clk);
    det_valid = 1'b0;
    llr_in    = ~mkLlr(base);
    checkOutput("out_valid_rise", 320'(out_valid), 320'(1));
    checkOutput("out_llr", 320'(out_llr), 320'(mkLlr(base)));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_is_r     = 1'b0;
    det_valid   = 1'b0;
    llr_in      = '0;
    out_ready   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 320'(in_ready), 320'(1));
    checkOutput("rst_busy", 320'(busy), 320'(0));
    checkOutput("rst_det_enable", 320'(det_enable), 320'(0));
    checkOutput("rst_det_cnt", 320'(det_cnt), 320'(0));
    checkOutput("rst_out_valid", 320'(out_valid), 320'(0));
    checkOutput("rst_err", 320'(err), 320'(0));
    checkOutput("rst_r", r_bus, 320'(0));
    checkOutput("rst_y", 320'(y_bus), 320'(0));
    checkOutput("rst_llr", 320'(out_llr), 320'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // y word with no R loaded is dropped and flagged.
    applyStimulus(77, 1, 1'b0);
    checkOutput("noR_err", 320'(err), 320'(1));
    checkOutput("noR_busy", 320'(busy), 320'(0));
    checkOutput("noR_y", 320'(y_bus), 320'(0));
    @(negedge clk);
    checkOutput("noR_err_pulse", 320'(err), 320'(0));
    checkOutput("noR_no_sweep", 320'(det_enable), 320'(0));

    // R burst 1..16 then y burst 101..108 back to back.
    applyStimulus(1, 16, 1'b1);
    checkOutput("r_done_busy", 320'(busy), 320'(0));
    checkOutput("r_done_ready", 320'(in_ready), 320'(1));
    checkR(1);
    applyStimulus(101, 8, 1'b0);
    checkY(101);
    runSweep(1'b0);
    checkR(1);
    checkY(101);
    deliverLlr(1);

    // Downstream stalls for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 320'(out_valid), 320'(1));
      checkOutput("hold_out_llr", 320'(out_llr), 320'(mkLlr(1)));
      checkOutput("hold_in_ready", 320'(in_ready), 320'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("hs_busy", 320'(busy), 320'(0));
    checkOutput("hs_in_ready", 320'(in_ready), 320'(1));
    checkOutput("hs_out_valid", 320'(out_valid), 320'(0));

    // Second y burst reuses the stored R.
    applyStimulus(201, 8, 1'b0);
    checkY(201);
    checkR(1);
    runSweep(1'b0);
    deliverLlr(11);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("hs2_busy", 320'(busy), 320'(0));

    // Detector never answers: 16 DRAIN cycles then an error pulse; a spurious valid in SWEEP is ignored.
    applyStimulus(301, 8, 1'b0);
    runSweep(1'b1);
    for (int k = 0; k < 16; k++) begin
      checkOutput("to_busy", 320'(busy), 320'(1));
      checkOutput("to_err", 320'(err), 320'(0));
      checkOutput("to_out_valid", 320'(out_valid), 320'(0));
      @(negedge clk);
    end
    checkOutput("to_err_pulse", 320'(err), 320'(1));
    checkOutput("to_idle", 320'(busy), 320'(0));
    checkOutput("to_no_out", 320'(out_valid), 320'(0));
    @(negedge clk);
    checkOutput("to_err_clear", 320'(err), 320'(0));

    // Reset in the middle of a sweep.
    applyStimulus(401, 8, 1'b0);
    for (int k = 0; k < 30; k++) @(negedge clk);
    checkOutput("pre_rst_cnt", 320'(det_cnt), 320'(30));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_enable", 320'(det_enable), 320'(0));
    checkOutput("mid_rst_cnt", 320'(det_cnt), 320'(0));
    checkOutput("mid_rst_busy", 320'(busy), 320'(0));
    checkOutput("mid_rst_r", r_bus, 320'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(501, 1, 1'b0);
    checkOutput("post_rst_err", 320'(err), 320'(1));
    checkOutput("post_rst_busy", 320'(busy), 320'(0));
    @(negedge clk);
    checkOutput("post_rst_no_sweep", 320'(det_enable), 320'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ml_seq_ctrl.md
# ml_seq_ctrl

Sequencing controller for the 4x4 QPSK ML detector datapath (`ml_x`-class LLR engine). It assembles the channel matrix R and the rotated receive vector y_hat from a 20-bit word stream into the detector's packed input buses. It then sweeps the 64-candidate counter and waits for the detector's LLR-valid. Finally, it captures the eight LLRs and hands them downstream over a valid/ready handshake. It sits between the QR/preprocessing front end and the LLR output path.

## Interface
- DATA_WIDTH, 20, width of each R / y_hat word
- TIMEOUT, 16, cycles DRAIN waits for i_det_valid before aborting
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_in_valid  in  1  input word valid
- o_in_ready  out  1  controller accepts word (transfer = valid & ready)
- i_in_data  in  DATA_WIDTH  R or y_hat word
- i_in_is_r  in  1  sampled on first word of a burst: 1 = R burst (16 words), 0 = y_hat burst (8 words)
- o_r  out  16*DATA_WIDTH  R bus; word k at [DW*k+DW-1 : DW*k], arrival order r11,r12re,r12im,r22,r13re,...,r44
- o_y_hat  out  8*DATA_WIDTH  y_hat bus; word k at [DW*k+DW-1 : DW*k], order y1re,y1im,...,y4im
- o_det_enable  out  1  detector enable, high only in SWEEP
- o_det_cnt  out  6  candidate index to detector
- i_det_valid  in  1  detector LLR valid
- i_llr  in  8*(DATA_WIDTH+2)  detector LLRs x11,x12,...,x42 (LSB first)
- o_out_valid  out  1  captured LLRs valid
- i_out_ready  in  1  downstream accepts
- o_out_llr  out  8*(DATA_WIDTH+2)  registered LLRs
- o_busy  out  1  state != IDLE
- o_err  out  1  one-cycle pulse: y burst with no R loaded, or DRAIN timeout

## Operation
- States: IDLE, LOAD_R, LOAD_Y, SWEEP, DRAIN, OUT.
- o_in_ready = 1 in IDLE, LOAD_R, LOAD_Y; 0 otherwise.
- In IDLE, an accepted word with is_r=1 is stored as R word 0, word_cnt=1, and the FSM goes to LOAD_R.
- In IDLE, an accepted word with is_r=0 and r_loaded=1 is stored as y word 0, and the FSM goes to LOAD_Y.
- In IDLE, an accepted word with is_r=0 and r_loaded=0 is dropped; o_err pulses and the FSM stays in IDLE.
- i_in_is_r is ignored after the first word of a burst.
- LOAD_R: each accepted word writes slot word_cnt. After slot 15 is written, r_loaded is set and the FSM returns to IDLE. R persists across any number of y bursts until the next R burst overwrites it.
- LOAD_Y: after slot 7 is written, the FSM goes to SWEEP with sweep_cnt=0.
- SWEEP: o_det_enable=1 and o_det_cnt=sweep_cnt, incrementing each cycle 0..63. After the cycle with cnt=63, the FSM goes to DRAIN.
- Outside SWEEP, o_det_cnt=0. It never holds 63, so the detector's done pipeline cannot retrigger.
- o_r and o_y_hat are stable from the end of loading through DRAIN; they are written only during LOAD states.
- DRAIN: on i_det_valid, i_llr is registered into o_out_llr and the FSM goes to OUT.
- DRAIN timeout: if TIMEOUT cycles pass with no i_det_valid, o_err pulses and the FSM goes to IDLE with no output.
- i_det_valid outside DRAIN is ignored.
- OUT: o_out_valid=1 and o_out_llr is held constant until i_out_ready. On the handshake the FSM goes to IDLE.
- Widths: word_cnt is 4 bits, sweep_cnt is 6 bits, the timeout counter is ceil(log2(TIMEOUT+1)) bits. No arithmetic is applied to data; LLRs pass bit-exact.

## Timing
- Reset (async, i_rst_n=0) clears:
  - state=IDLE, r_loaded=0;
  - o_r, o_y_hat and o_out_llr to 0;
  - o_det_enable, o_det_cnt, o_out_valid, o_busy and o_err to 0; o_in_ready=1 after reset.
- Reset mid-operation aborts immediately, and the stored R is lost.
- If the last y word is accepted at edge T, then o_det_enable=1 and cnt=0 in the cycle after T, and cnt=63 in cycle T+64.
- With the nominal detector latency of 5, i_det_valid arrives in cycle T+69 and o_out_valid rises in the following cycle.
- Word transfer occurs only on valid & ready at the clock edge. Back-to-back words are accepted at 1 per cycle.
- On the OUT handshake edge, the FSM returns to IDLE and o_in_ready rises in the next cycle. There is no same-cycle input acceptance.
- o_out_valid, once asserted, does not drop and o_out_llr does not change before the handshake.
- o_err is a single-cycle pulse registered in the cycle after the triggering event.

## Test plan
- Load R words 1..16, then y words 101..108 back-to-back -> o_r word k = k+1, o_y_hat word k = 101+k; o_det_cnt steps 0..63 with enable high for exactly 64 cycles.
- Detector model returns i_det_valid 5 cycles after cnt=63 with LLR words 1..8 -> o_out_valid one cycle later, o_out_llr = 1..8.
- Hold i_out_ready=0 for 10 cycles -> o_out_valid and o_out_llr remain stable and o_in_ready=0; on ready=1, the FSM is IDLE the next cycle.
- After reset, send a y burst first -> word dropped, one o_err pulse, no SWEEP. Next, send two y bursts after a single R load -> two full sweeps using the same o_r.
- Suppress i_det_valid -> after 16 DRAIN cycles, o_err pulses, the FSM returns to IDLE and o_out_valid is never asserted.
- Assert i_rst_n=0 at sweep cnt=30 -> o_det_enable, o_det_cnt and o_busy are 0 immediately and r_loaded is cleared, so a subsequent y burst raises o_err.
